// File: rtl/ex_stage_pkg.sv
// Shared decode/execute definitions: operation codes, result classes, bus widths
// and the types used by the execute stage and its iterative multiplier.
package ex_stage_pkg;

  localparam int ALU_OP_W   = 8;
  localparam int ALU_SEL_W  = 3;
  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_W-1:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [ALU_OP_W-1:0] NOP_OP   = 8'b00000000;
  localparam logic [ALU_OP_W-1:0] AND_OP   = 8'b00100100;
  localparam logic [ALU_OP_W-1:0] OR_OP    = 8'b00100101;
  localparam logic [ALU_OP_W-1:0] XOR_OP   = 8'b00100110;
  localparam logic [ALU_OP_W-1:0] NOR_OP   = 8'b00100111;
  localparam logic [ALU_OP_W-1:0] SLL_OP   = 8'b01111100;
  localparam logic [ALU_OP_W-1:0] SRL_OP   = 8'b00000010;
  localparam logic [ALU_OP_W-1:0] SRA_OP   = 8'b00000011;
  localparam logic [ALU_OP_W-1:0] MULTU_OP = 8'b00011001;

  localparam logic [ALU_SEL_W-1:0] RES_NOP   = 3'b000;
  localparam logic [ALU_SEL_W-1:0] RES_LOGIC = 3'b001;
  localparam logic [ALU_SEL_W-1:0] RES_SHIFT = 3'b010;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  typedef struct packed {
    logic                  wreg;
    logic [REG_ADDR_W-1:0] wd;
    logic [REG_W-1:0]      wdata;
    logic                  whilo;
    logic [REG_W-1:0]      hi;
    logic [REG_W-1:0]      lo;
  } ex_out_t;

  function automatic logic [REG_W-1:0] sra32(input logic [REG_W-1:0] v,
                                             input logic [4:0] sh);
    return $signed(v) >>> sh;
  endfunction

endpackage

// File: rtl/ex_stage_mul_iter.sv
// Unsigned 32x32 shift-add multiplier, one multiplier bit per cycle.
// The result stays in DONE until the downstream hold is released.
module mul_iter
  import ex_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic             hold,
  input  logic [REG_W-1:0] a,
  input  logic [REG_W-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [63:0]      prod
);

  mul_state_e       state;
  logic [4:0]       count;
  logic [63:0]      mcand;
  logic [REG_W-1:0] mplier;
  logic [63:0]      acc;

  // Flush discards the partial product regardless of state or hold.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state  <= MUL_IDLE;
      count  <= 5'd0;
      acc    <= 64'd0;
      mcand  <= 64'd0;
      mplier <= 32'd0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (start) begin
            mcand  <= {32'd0, a};
            mplier <= b;
            acc    <= 64'd0;
            count  <= 5'd0;
            state  <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 5'd1;
          if (count == 5'd31) begin
            state <= MUL_DONE;
          end
        end
        MUL_DONE: begin
          if (!hold) begin
            state <= MUL_IDLE;
          end
        end
        default: state <= MUL_IDLE;
      endcase
    end
  end

  assign busy = (state == MUL_RUN);
  assign done = (state == MUL_DONE);
  assign prod = acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: logic/shift ALU with same-cycle forwarding to decode,
// iterative MULTU, and the EX/MEM output register with stall/flush control.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ALU_OP_W-1:0]   aluop_i,
  input  logic [ALU_SEL_W-1:0]  alusel_i,
  input  logic [REG_W-1:0]      reg1_i,
  input  logic [REG_W-1:0]      reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic                  ex_wreg_o,
  output logic [REG_ADDR_W-1:0] ex_wd_o,
  output logic [REG_W-1:0]      ex_wdata_o,
  output logic                  stallreq_o,
  output logic                  mem_wreg_o,
  output logic [REG_ADDR_W-1:0] mem_wd_o,
  output logic [REG_W-1:0]      mem_wdata_o,
  output logic                  mem_whilo_o,
  output logic [REG_W-1:0]      mem_hi_o,
  output logic [REG_W-1:0]      mem_lo_o
);

  logic             is_multu;
  logic             mul_busy;
  logic             mul_done;
  logic             mul_idle;
  logic             mul_start;
  logic [63:0]      mul_prod;
  logic [REG_W-1:0] alu_res;
  ex_out_t          cur;
  ex_out_t          out_r;

  assign is_multu  = (aluop_i == MULTU_OP);
  assign mul_idle  = !mul_busy && !mul_done;
  assign mul_start = is_multu && mul_idle && !rst;

  mul_iter u_mul (
    .clk  (clk),
    .rst  (rst),
    .start(mul_start),
    .flush(flush_i),
    .hold (stall_i),
    .a    (reg1_i),
    .b    (reg2_i),
    .busy (mul_busy),
    .done (mul_done),
    .prod (mul_prod)
  );

  // Result mux; unlisted op/class pairs yield zero.
  always_comb begin
    alu_res = ZERO_WORD;
    case (alusel_i)
      RES_LOGIC: begin
        case (aluop_i)
          OR_OP:   alu_res = reg1_i | reg2_i;
          AND_OP:  alu_res = reg1_i & reg2_i;
          XOR_OP:  alu_res = reg1_i ^ reg2_i;
          NOR_OP:  alu_res = ~(reg1_i | reg2_i);
          default: alu_res = ZERO_WORD;
        endcase
      end
      RES_SHIFT: begin
        case (aluop_i)
          SLL_OP:  alu_res = reg2_i << reg1_i[4:0];
          SRL_OP:  alu_res = reg2_i >> reg1_i[4:0];
          SRA_OP:  alu_res = sra32(reg2_i, reg1_i[4:0]);
          default: alu_res = ZERO_WORD;
        endcase
      end
      default: alu_res = ZERO_WORD;
    endcase
  end

  assign ex_wdata_o = rst ? ZERO_WORD : alu_res;
  assign ex_wd_o    = rst ? 5'd0 : wd_i;
  assign ex_wreg_o  = rst ? 1'b0 : (wreg_i && !is_multu);

  // Held high while accepting or iterating so decode advances only out of DONE.
  assign stallreq_o = !rst && !flush_i && (mul_busy || (is_multu && mul_idle));

  // Only the DONE cycle of a MULTU carries HI/LO.
  always_comb begin
    cur       = '0;
    cur.wreg  = ex_wreg_o;
    cur.wd    = ex_wd_o;
    cur.wdata = ex_wdata_o;
    if (mul_done && is_multu) begin
      cur.whilo = 1'b1;
      cur.hi    = mul_prod[63:32];
      cur.lo    = mul_prod[31:0];
    end else begin
      cur.whilo = 1'b0;
    end
  end

  // EX/MEM register: flush beats stall, stall holds, an in-flight multiply sends bubbles.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      out_r <= '0;
    end else if (stall_i) begin
      out_r <= out_r;
    end else if (stallreq_o) begin
      out_r <= '0;
    end else begin
      out_r <= cur;
    end
  end

  assign mem_wreg_o  = out_r.wreg;
  assign mem_wd_o    = out_r.wd;
  assign mem_wdata_o = out_r.wdata;
  assign mem_whilo_o = out_r.whilo;
  assign mem_hi_o    = out_r.hi;
  assign mem_lo_o    = out_r.lo;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized ALU, stall/flush
// and MULTU traffic compared against an arithmetic reference model.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i, reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i, stall_i, flush_i;
  logic        ex_wreg_o, stallreq_o, mem_wreg_o, mem_whilo_o;
  logic [4:0]  ex_wd_o, mem_wd_o;
  logic [31:0] ex_wdata_o, mem_wdata_o, mem_hi_o, mem_lo_o;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] op_tab[10];
  logic [2:0] sel_tab[10];

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .ex_wreg_o(ex_wreg_o), .ex_wd_o(ex_wd_o), .ex_wdata_o(ex_wdata_o),
    .stallreq_o(stallreq_o), .mem_wreg_o(mem_wreg_o), .mem_wd_o(mem_wd_o),
    .mem_wdata_o(mem_wdata_o), .mem_whilo_o(mem_whilo_o),
    .mem_hi_o(mem_hi_o), .mem_lo_o(mem_lo_o)
  );

  function automatic logic [31:0] model_alu(input logic [7:0] op, input logic [2:0] sel,
                                            input logic [31:0] r1, input logic [31:0] r2);
    logic [63:0] ext;
    ext = {{32{r2[31]}}, r2} >> r1[4:0];
    if (sel == 3'b001 && op == 8'b00100101) return r1 | r2;
    if (sel == 3'b001 && op == 8'b00100100) return r1 & r2;
    if (sel == 3'b001 && op == 8'b00100110) return r1 ^ r2;
    if (sel == 3'b001 && op == 8'b00100111) return ~(r1 | r2);
    if (sel == 3'b010 && op == 8'b01111100) return r2 << r1[4:0];
    if (sel == 3'b010 && op == 8'b00000010) return r2 >> r1[4:0];
    if (sel == 3'b010 && op == 8'b00000011) return ext[31:0];
    return 32'h0;
  endfunction

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [4:0] wd, input logic wreg);
    aluop_i = op; alusel_i = sel; reg1_i = r1; reg2_i = r2; wd_i = wd; wreg_i = wreg;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    drive(8'b00100101, 3'b001, $urandom, $urandom, 5'd9, 1'b1);
    #1;
    n_cmp++;
    if (ex_wdata_o !== 32'h0 || ex_wreg_o !== 1'b0 || ex_wd_o !== 5'd0) begin
      n_fail++; $display("FAIL reset_fwd: got wdata=%h wreg=%b wd=%0d, want all 0", ex_wdata_o, ex_wreg_o, ex_wd_o);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({mem_wreg_o, mem_wd_o, mem_wdata_o, mem_whilo_o, mem_hi_o, mem_lo_o, stallreq_o} !== '0) begin
      n_fail++; $display("FAIL reset_mem: got wreg=%b wd=%0d wdata=%h whilo=%b hi=%h lo=%h stallreq=%b, want all 0",
                         mem_wreg_o, mem_wd_o, mem_wdata_o, mem_whilo_o, mem_hi_o, mem_lo_o, stallreq_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_logic();
    drive(8'b00100101, 3'b001, 32'h0000F0F0, 32'h12340F0F, 5'd5, 1'b1);
    #1;
    n_cmp++;
    if (ex_wdata_o !== 32'h1234FFFF || ex_wd_o !== 5'd5 || ex_wreg_o !== 1'b1) begin
      n_fail++; $display("FAIL or_fwd: got %h/%0d/%b, want 1234ffff/5/1", ex_wdata_o, ex_wd_o, ex_wreg_o);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (mem_wdata_o !== 32'h1234FFFF || mem_wd_o !== 5'd5 || mem_wreg_o !== 1'b1 || mem_whilo_o !== 1'b0) begin
      n_fail++; $display("FAIL or_mem: got %h/%0d/%b whilo=%b, want 1234ffff/5/1 whilo=0",
                         mem_wdata_o, mem_wd_o, mem_wreg_o, mem_whilo_o);
    end
  endtask

  task automatic test_shift();
    drive(8'b00000011, 3'b010, 32'd4, 32'h80000010, 5'd7, 1'b1);
    #1;
    n_cmp++;
    if (ex_wdata_o !== 32'hF8000001) begin
      n_fail++; $display("FAIL sra: got %h, want f8000001", ex_wdata_o);
    end
    @(posedge clk); #1;
    drive(8'b01111100, 3'b010, 32'hFFFFFFE3, 32'd1, 5'd8, 1'b1);
    #1;
    n_cmp++;
    if (ex_wdata_o !== 32'd8) begin
      n_fail++; $display("FAIL sll_hi_bits: got %h, want 00000008", ex_wdata_o);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (mem_wdata_o !== 32'd8 || mem_wd_o !== 5'd8) begin
      n_fail++; $display("FAIL sll_mem: got %h/%0d, want 00000008/8", mem_wdata_o, mem_wd_o);
    end
  endtask

  // Random ALU traffic with random stall/flush; expected MEM image kept as plain variables.
  task automatic test_back_to_back();
    logic [31:0] e_wdata, m;
    logic [4:0]  e_wd;
    logic        e_wreg;
    int          k;
    e_wdata = 32'h0; e_wd = 5'd0; e_wreg = 1'b0;
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 9);
      drive(op_tab[k], sel_tab[k], $urandom, $urandom, 5'($urandom), 1'($urandom));
      stall_i = (i == 0) ? 1'b0 : ($urandom_range(0, 3) == 0);
      flush_i = ($urandom_range(0, 7) == 0);
      m = model_alu(aluop_i, alusel_i, reg1_i, reg2_i);
      #1;
      n_cmp++;
      if (ex_wdata_o !== m || ex_wreg_o !== wreg_i || ex_wd_o !== wd_i || stallreq_o !== 1'b0) begin
        n_fail++; $display("FAIL b2b_fwd[%0d]: op=%h sel=%0d got %h/%b/%0d sr=%b, want %h/%b/%0d sr=0",
                           i, aluop_i, alusel_i, ex_wdata_o, ex_wreg_o, ex_wd_o, stallreq_o, m, wreg_i, wd_i);
      end
      if (flush_i) begin
        e_wdata = 32'h0; e_wd = 5'd0; e_wreg = 1'b0;
      end else if (!stall_i) begin
        e_wdata = m; e_wd = wd_i; e_wreg = wreg_i;
      end
      @(posedge clk); #1;
      n_cmp++;
      if (mem_wdata_o !== e_wdata || mem_wd_o !== e_wd || mem_wreg_o !== e_wreg || mem_whilo_o !== 1'b0) begin
        n_fail++; $display("FAIL b2b_mem[%0d]: got %h/%0d/%b whilo=%b, want %h/%0d/%b whilo=0",
                           i, mem_wdata_o, mem_wd_o, mem_wreg_o, mem_whilo_o, e_wdata, e_wd, e_wreg);
      end
    end
    stall_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic test_multu(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int          cnt;
    logic        early;
    p = {32'd0, a} * {32'd0, b};
    cnt = 0; early = 1'b0;
    drive(8'b00011001, 3'b000, a, b, 5'd0, 1'b0);
    #1;
    while (stallreq_o === 1'b1 && cnt < 40) begin
      cnt++;
      @(posedge clk); #1;
      if (mem_whilo_o !== 1'b0 || mem_wreg_o !== 1'b0) early = 1'b1;
    end
    n_cmp++;
    if (cnt != 33 || early) begin
      n_fail++; $display("FAIL multu_stallreq: got %0d cycles early_out=%b, want 33 cycles early_out=0", cnt, early);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (mem_hi_o !== p[63:32] || mem_lo_o !== p[31:0] || mem_whilo_o !== 1'b1 || mem_wreg_o !== 1'b0) begin
      n_fail++; $display("FAIL multu_result: %h*%h got hi=%h lo=%h whilo=%b wreg=%b, want hi=%h lo=%h whilo=1 wreg=0",
                         a, b, mem_hi_o, mem_lo_o, mem_whilo_o, mem_wreg_o, p[63:32], p[31:0]);
    end
    drive(8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    @(posedge clk); #1;
    n_cmp++;
    if (mem_whilo_o !== 1'b0) begin
      n_fail++; $display("FAIL multu_single_pulse: got whilo=%b, want 0", mem_whilo_o);
    end
  endtask

  task automatic test_multu_stall();
    logic [31:0] a, b;
    logic [63:0] p;
    int          cnt, pulses;
    a = $urandom; b = $urandom;
    p = {32'd0, a} * {32'd0, b};
    cnt = 0; pulses = 0;
    drive(8'b00011001, 3'b000, a, b, 5'd0, 1'b0);
    #1;
    while (stallreq_o === 1'b1 && cnt < 40) begin
      cnt++;
      @(posedge clk); #1;
    end
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (mem_whilo_o !== 1'b0 || stallreq_o !== 1'b0) begin
        n_fail++; $display("FAIL stall_done_hold[%0d]: got whilo=%b stallreq=%b, want 0/0", i, mem_whilo_o, stallreq_o);
      end
    end
    stall_i = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (mem_whilo_o !== 1'b1 || mem_hi_o !== p[63:32] || mem_lo_o !== p[31:0]) begin
      n_fail++; $display("FAIL stall_release: got whilo=%b hi=%h lo=%h, want 1 %h %h",
                         mem_whilo_o, mem_hi_o, mem_lo_o, p[63:32], p[31:0]);
    end
    drive(8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (mem_whilo_o === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL stall_extra_pulse: got %0d extra whilo pulses, want 0", pulses);
    end
  endtask

  task automatic test_flush();
    drive(8'b00011001, 3'b000, $urandom, $urandom, 5'd0, 1'b0);
    #1;
    repeat (11) @(posedge clk);
    #1;
    n_cmp++;
    if (stallreq_o !== 1'b1) begin
      n_fail++; $display("FAIL flush_pre: got stallreq=%b at count 10, want 1", stallreq_o);
    end
    flush_i = 1'b1;
    #1;
    n_cmp++;
    if (stallreq_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_stallreq: got %b, want 0", stallreq_o);
    end
    @(posedge clk); #1;
    flush_i = 1'b0;
    n_cmp++;
    if ({mem_wreg_o, mem_wdata_o, mem_whilo_o, mem_hi_o, mem_lo_o} !== '0) begin
      n_fail++; $display("FAIL flush_bubble: got wreg=%b wdata=%h whilo=%b hi=%h lo=%h, want all 0",
                         mem_wreg_o, mem_wdata_o, mem_whilo_o, mem_hi_o, mem_lo_o);
    end
    test_multu(32'd3, 32'd5);
  endtask

  task automatic test_rst_mid();
    logic [31:0] r1, r2;
    drive(8'b00011001, 3'b000, $urandom, $urandom, 5'd0, 1'b0);
    #1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({mem_wreg_o, mem_wd_o, mem_wdata_o, mem_whilo_o, mem_hi_o, mem_lo_o, stallreq_o, ex_wdata_o, ex_wreg_o} !== '0) begin
      n_fail++; $display("FAIL rst_mid: got wreg=%b wdata=%h whilo=%b stallreq=%b ex_wdata=%h, want all 0",
                         mem_wreg_o, mem_wdata_o, mem_whilo_o, stallreq_o, ex_wdata_o);
    end
    rst = 1'b0;
    r1 = $urandom; r2 = $urandom;
    drive(8'b00100101, 3'b001, r1, r2, 5'd17, 1'b1);
    #1;
    n_cmp++;
    if (ex_wdata_o !== (r1 | r2) || stallreq_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_after_fwd: got %h sr=%b, want %h sr=0", ex_wdata_o, stallreq_o, r1 | r2);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (mem_wdata_o !== (r1 | r2) || mem_wd_o !== 5'd17 || mem_wreg_o !== 1'b1 || mem_whilo_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_after_mem: got %h/%0d/%b/%b, want %h/17/1/0",
                         mem_wdata_o, mem_wd_o, mem_wreg_o, mem_whilo_o, r1 | r2);
    end
  endtask

  initial begin
    op_tab[0] = 8'b00100101; sel_tab[0] = 3'b001;
    op_tab[1] = 8'b00100100; sel_tab[1] = 3'b001;
    op_tab[2] = 8'b00100110; sel_tab[2] = 3'b001;
    op_tab[3] = 8'b00100111; sel_tab[3] = 3'b001;
    op_tab[4] = 8'b01111100; sel_tab[4] = 3'b010;
    op_tab[5] = 8'b00000010; sel_tab[5] = 3'b010;
    op_tab[6] = 8'b00000011; sel_tab[6] = 3'b010;
    op_tab[7] = 8'b00000000; sel_tab[7] = 3'b000;
    op_tab[8] = 8'b01111100; sel_tab[8] = 3'b001;
    op_tab[9] = 8'b00100101; sel_tab[9] = 3'b111;
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    drive(8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    @(posedge clk); #1;
    test_reset();
    test_logic();
    test_shift();
    test_back_to_back();
    test_multu(32'hFFFFFFFF, 32'd2);
    for (int i = 0; i < 3; i++) test_multu($urandom, $urandom);
    test_multu_stall();
    test_flush();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
